// File: rtl/mem_rd_wr_arbiter_if.sv
// Cache-side and memory-side handshake bundle for mem_rd_wr_arbiter.
// "master" is the arbiter view, "slave" is the caches/memory-bridge view.
interface mem_rd_wr_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int BLK_W  = 128
);
   logic [3:0]        ic_ren;
   logic [ADDR_W-1:0] ic_raddr;
   logic              ic_abort;
   logic              ic_rrdy;
   logic              ic_rvalid;
   logic [BLK_W-1:0]  ic_rdata;
   logic [3:0]        dc_ren;
   logic [ADDR_W-1:0] dc_raddr;
   logic              dc_rrdy;
   logic              dc_rvalid;
   logic [BLK_W-1:0]  dc_rdata;
   logic [3:0]        dc_wen;
   logic [ADDR_W-1:0] dc_waddr;
   logic [BLK_W-1:0]  dc_wdata;
   logic              dc_wrdy;
   logic              dc_bvalid;
   logic              mem_rrdy;
   logic [3:0]        mem_ren;
   logic [ADDR_W-1:0] mem_raddr;
   logic              mem_rvalid;
   logic [BLK_W-1:0]  mem_rdata;
   logic              mem_wrdy;
   logic [3:0]        mem_wen;
   logic [ADDR_W-1:0] mem_waddr;
   logic [BLK_W-1:0]  mem_wdata;
   logic              mem_bvalid;

   modport master (
      input  ic_ren, ic_raddr, ic_abort,
      output ic_rrdy, ic_rvalid, ic_rdata,
      input  dc_ren, dc_raddr,
      output dc_rrdy, dc_rvalid, dc_rdata,
      input  dc_wen, dc_waddr, dc_wdata,
      output dc_wrdy, dc_bvalid,
      input  mem_rrdy, mem_rvalid, mem_rdata, mem_wrdy, mem_bvalid,
      output mem_ren, mem_raddr, mem_wen, mem_waddr, mem_wdata
   );

   modport slave (
      output ic_ren, ic_raddr, ic_abort,
      input  ic_rrdy, ic_rvalid, ic_rdata,
      output dc_ren, dc_raddr,
      input  dc_rrdy, dc_rvalid, dc_rdata,
      output dc_wen, dc_waddr, dc_wdata,
      input  dc_wrdy, dc_bvalid,
      output mem_rrdy, mem_rvalid, mem_rdata, mem_wrdy, mem_bvalid,
      input  mem_ren, mem_raddr, mem_wen, mem_waddr, mem_wdata
   );
endinterface

// File: rtl/mem_rd_wr_arbiter.sv
// Arbitrates the single main-memory bus between ICache refill, DCache refill and
// DCache write-back; one outstanding transaction, responses routed to the owner.
module mem_rd_wr_arbiter #(
   parameter int ADDR_W       = 32,
   parameter int BLK_W        = 128,
   parameter int STARVE_LIMIT = 2
) (
   input  logic                cpu_clk,
   input  logic                cpu_rstn,
   mem_rd_wr_arbiter_if.master bus
);
   localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_IC_RD = 2'd1;
   localparam logic [1:0] S_DC_RD = 2'd2;
   localparam logic [1:0] S_DC_WR = 2'd3;

   logic [1:0]        r_state;
   logic              r_ic_pend;
   logic              r_dcr_pend;
   logic              r_dcw_pend;
   logic              r_ic_abort;
   logic [ADDR_W-1:0] r_ic_addr;
   logic [ADDR_W-1:0] r_dcr_addr;
   logic [ADDR_W-1:0] r_dcw_addr;
   logic [BLK_W-1:0]  r_dcw_data;
   logic [CNT_W-1:0]  r_starve_cnt;
   logic [3:0]        r_mem_ren;
   logic [3:0]        r_mem_wen;
   logic [ADDR_W-1:0] r_mem_raddr;
   logic [ADDR_W-1:0] r_mem_waddr;
   logic [BLK_W-1:0]  r_mem_wdata;

   logic w_ic_rrdy;
   logic w_dc_rrdy;
   logic w_dc_wrdy;
   logic w_ic_cap;
   logic w_dcr_cap;
   logic w_dcw_cap;
   logic w_ic_pend;
   logic w_sel_ic;
   logic w_sel_dcr;
   logic w_sel_dcw;
   logic w_gnt_ic;
   logic w_gnt_dcr;
   logic w_gnt_dcw;

   // A source is ready only when its slot is empty and it owns no in-flight transaction.
   assign w_ic_rrdy = !r_ic_pend  && (r_state != S_IC_RD);
   assign w_dc_rrdy = !r_dcr_pend && (r_state != S_DC_RD);
   assign w_dc_wrdy = !r_dcw_pend && (r_state != S_DC_WR);

   assign w_ic_cap  = (bus.ic_ren != 4'h0) && w_ic_rrdy && !bus.ic_abort;
   assign w_dcr_cap = (bus.dc_ren != 4'h0) && w_dc_rrdy;
   assign w_dcw_cap = (bus.dc_wen != 4'h0) && w_dc_wrdy;
   assign w_ic_pend = r_ic_pend && !bus.ic_abort;

   // Grant selection: write > read > IC, unless the IC read has starved long enough.
   always_comb begin
      w_sel_ic  = 1'b0;
      w_sel_dcr = 1'b0;
      w_sel_dcw = 1'b0;
      if (r_state == S_IDLE) begin
         if (w_ic_pend && (r_starve_cnt == CNT_MAX)) begin
            w_sel_ic = 1'b1;
         end else if (r_dcw_pend) begin
            w_sel_dcw = 1'b1;
         end else if (r_dcr_pend) begin
            w_sel_dcr = 1'b1;
         end else if (w_ic_pend) begin
            w_sel_ic = 1'b1;
         end else begin
            w_sel_ic = 1'b0;
         end
      end else begin
         w_sel_ic = 1'b0;
      end
   end

   // The chosen source stalls on its own memory ready; lower priorities never slip past.
   assign w_gnt_ic  = w_sel_ic  && bus.mem_rrdy;
   assign w_gnt_dcr = w_sel_dcr && bus.mem_rrdy;
   assign w_gnt_dcw = w_sel_dcw && bus.mem_wrdy;

   // Transaction state, abort flag and starvation counter.
   always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
      if (!cpu_rstn) begin
         r_state      <= S_IDLE;
         r_ic_abort   <= 1'b0;
         r_starve_cnt <= {CNT_W{1'b0}};
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_gnt_ic) begin
                  r_state <= S_IC_RD;
               end else if (w_gnt_dcr) begin
                  r_state <= S_DC_RD;
               end else if (w_gnt_dcw) begin
                  r_state <= S_DC_WR;
               end else begin
                  r_state <= S_IDLE;
               end
            end
            S_IC_RD: r_state <= bus.mem_rvalid ? S_IDLE : S_IC_RD;
            S_DC_RD: r_state <= bus.mem_rvalid ? S_IDLE : S_DC_RD;
            S_DC_WR: r_state <= bus.mem_bvalid ? S_IDLE : S_DC_WR;
            default: r_state <= S_IDLE;
         endcase

         if ((r_state == S_IC_RD) && bus.mem_rvalid) begin
            r_ic_abort <= 1'b0;
         end else if ((r_state == S_IC_RD) && bus.ic_abort) begin
            r_ic_abort <= 1'b1;
         end else begin
            r_ic_abort <= r_ic_abort;
         end

         if (!w_ic_pend || w_gnt_ic) begin
            r_starve_cnt <= {CNT_W{1'b0}};
         end else if ((w_gnt_dcr || w_gnt_dcw) && (r_starve_cnt != CNT_MAX)) begin
            r_starve_cnt <= r_starve_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
         end else begin
            r_starve_cnt <= r_starve_cnt;
         end
      end
   end

   // Per-source pending slots; an abort beats a same-cycle IC request.
   always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
      if (!cpu_rstn) begin
         r_ic_pend  <= 1'b0;
         r_dcr_pend <= 1'b0;
         r_dcw_pend <= 1'b0;
         r_ic_addr  <= {ADDR_W{1'b0}};
         r_dcr_addr <= {ADDR_W{1'b0}};
         r_dcw_addr <= {ADDR_W{1'b0}};
         r_dcw_data <= {BLK_W{1'b0}};
      end else begin
         if (w_ic_cap) begin
            r_ic_pend <= 1'b1;
            r_ic_addr <= bus.ic_raddr;
         end else if (bus.ic_abort || w_gnt_ic) begin
            r_ic_pend <= 1'b0;
         end else begin
            r_ic_pend <= r_ic_pend;
         end

         if (w_dcr_cap) begin
            r_dcr_pend <= 1'b1;
            r_dcr_addr <= bus.dc_raddr;
         end else if (w_gnt_dcr) begin
            r_dcr_pend <= 1'b0;
         end else begin
            r_dcr_pend <= r_dcr_pend;
         end

         if (w_dcw_cap) begin
            r_dcw_pend <= 1'b1;
            r_dcw_addr <= bus.dc_waddr;
            r_dcw_data <= bus.dc_wdata;
         end else if (w_gnt_dcw) begin
            r_dcw_pend <= 1'b0;
         end else begin
            r_dcw_pend <= r_dcw_pend;
         end
      end
   end

   // Registered memory-side request; enables pulse for one cycle, address/data hold.
   always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
      if (!cpu_rstn) begin
         r_mem_ren   <= 4'h0;
         r_mem_wen   <= 4'h0;
         r_mem_raddr <= {ADDR_W{1'b0}};
         r_mem_waddr <= {ADDR_W{1'b0}};
         r_mem_wdata <= {BLK_W{1'b0}};
      end else begin
         r_mem_ren <= (w_gnt_ic || w_gnt_dcr) ? 4'hF : 4'h0;
         r_mem_wen <= w_gnt_dcw ? 4'hF : 4'h0;
         if (w_gnt_ic) begin
            r_mem_raddr <= r_ic_addr;
         end else if (w_gnt_dcr) begin
            r_mem_raddr <= r_dcr_addr;
         end else begin
            r_mem_raddr <= r_mem_raddr;
         end
         if (w_gnt_dcw) begin
            r_mem_waddr <= r_dcw_addr;
            r_mem_wdata <= r_dcw_data;
         end else begin
            r_mem_waddr <= r_mem_waddr;
            r_mem_wdata <= r_mem_wdata;
         end
      end
   end

   assign bus.ic_rrdy   = w_ic_rrdy;
   assign bus.dc_rrdy   = w_dc_rrdy;
   assign bus.dc_wrdy   = w_dc_wrdy;
   assign bus.ic_rvalid = (r_state == S_IC_RD) && bus.mem_rvalid && !r_ic_abort && !bus.ic_abort;
   assign bus.dc_rvalid = (r_state == S_DC_RD) && bus.mem_rvalid;
   assign bus.dc_bvalid = (r_state == S_DC_WR) && bus.mem_bvalid;
   assign bus.ic_rdata  = bus.mem_rdata;
   assign bus.dc_rdata  = bus.mem_rdata;
   assign bus.mem_ren   = r_mem_ren;
   assign bus.mem_wen   = r_mem_wen;
   assign bus.mem_raddr = r_mem_raddr;
   assign bus.mem_waddr = r_mem_waddr;
   assign bus.mem_wdata = r_mem_wdata;
endmodule

// File: tb/tb_mem_rd_wr_arbiter.sv
// Directed bench for mem_rd_wr_arbiter: a small memory responder logs every issued
// transaction and every response pulse; scenario tasks compare against hand values.
module tb_mem_rd_wr_arbiter;
   localparam int ADDR_W = 32;
   localparam int BLK_W  = 128;

   logic cpu_clk  = 1'b0;
   logic cpu_rstn = 1'b0;
   int   tests    = 0;
   int   fails    = 0;

   mem_rd_wr_arbiter_if #(.ADDR_W(ADDR_W), .BLK_W(BLK_W)) bus ();

   mem_rd_wr_arbiter #(.ADDR_W(ADDR_W), .BLK_W(BLK_W), .STARVE_LIMIT(2)) dut (
      .cpu_clk (cpu_clk),
      .cpu_rstn(cpu_rstn),
      .bus     (bus)
   );

   always #5 cpu_clk = ~cpu_clk;

   function automatic logic [BLK_W-1:0] mk_data(input logic [ADDR_W-1:0] a);
      return {a ^ 32'h1111_1111, a, ~a, a + 32'h0000_0005};
   endfunction

   logic [ADDR_W:0]  txn_q[$];
   int               txn_cyc[$];
   int               cyc = 0;
   int               ic_rv_cnt = 0, dc_rv_cnt = 0, bv_cnt = 0, mem_rv_cnt = 0, overlap_cnt = 0;
   int               dc_rv_cyc = 0, bv_cyc = 0;
   logic [BLK_W-1:0] ic_last = '0, dc_last = '0, wdata_last = '0;
   int               lat = 1;
   int               spur_req = 0, spur_done = 0;

   // Memory model: answers each issued transaction after lat idle cycles; logs outputs at negedge+1.
   initial begin : responder
      logic             rd_busy, wr_busy;
      int               rd_wait, wr_wait;
      logic [BLK_W-1:0] rd_data;
      rd_busy = 1'b0; wr_busy = 1'b0; rd_wait = 0; wr_wait = 0; rd_data = '0;
      bus.mem_rvalid = 1'b0; bus.mem_bvalid = 1'b0; bus.mem_rdata = '0;
      forever begin
         @(negedge cpu_clk);
         cyc++;
         bus.mem_rvalid = 1'b0;
         bus.mem_bvalid = 1'b0;
         if (!cpu_rstn) begin
            rd_busy = 1'b0;
            wr_busy = 1'b0;
         end else begin
            if (rd_busy) begin
               if (rd_wait == 0) begin
                  bus.mem_rvalid = 1'b1; bus.mem_rdata = rd_data; rd_busy = 1'b0; mem_rv_cnt++;
               end else rd_wait--;
            end else if (!wr_busy && spur_req != spur_done) begin
               bus.mem_rvalid = 1'b1; bus.mem_bvalid = 1'b1; bus.mem_rdata = '1; spur_done++;
            end
            if (wr_busy) begin
               if (wr_wait == 0) begin
                  bus.mem_bvalid = 1'b1; wr_busy = 1'b0;
               end else wr_wait--;
            end
         end
         #1;
         if (bus.mem_ren != 4'h0 && bus.mem_wen != 4'h0) overlap_cnt++;
         if (bus.mem_ren != 4'h0) begin
            txn_q.push_back({1'b0, bus.mem_raddr}); txn_cyc.push_back(cyc);
            rd_busy = 1'b1; rd_wait = lat; rd_data = mk_data(bus.mem_raddr);
         end
         if (bus.mem_wen != 4'h0) begin
            txn_q.push_back({1'b1, bus.mem_waddr}); txn_cyc.push_back(cyc);
            wdata_last = bus.mem_wdata; wr_busy = 1'b1; wr_wait = lat;
         end
         if (bus.ic_rvalid) begin ic_rv_cnt++; ic_last = bus.ic_rdata; end
         if (bus.dc_rvalid) begin dc_rv_cnt++; dc_last = bus.dc_rdata; dc_rv_cyc = cyc; end
         if (bus.dc_bvalid) begin bv_cnt++; bv_cyc = cyc; end
      end
   end

   task automatic send(input logic ic, input logic [31:0] ia, input logic dr, input logic [31:0] ra,
                       input logic dw, input logic [31:0] wa, input logic [127:0] wd);
      @(negedge cpu_clk);
      bus.ic_ren = ic ? 4'hF : 4'h0; bus.ic_raddr = ia;
      bus.dc_ren = dr ? 4'hF : 4'h0; bus.dc_raddr = ra;
      bus.dc_wen = dw ? 4'hF : 4'h0; bus.dc_waddr = wa; bus.dc_wdata = wd;
      @(negedge cpu_clk);
      bus.ic_ren = 4'h0; bus.dc_ren = 4'h0; bus.dc_wen = 4'h0;
   endtask

   task automatic wait_txn(input int n, input string tag);
      int i;
      i = 0;
      while (txn_q.size() < n && i < 60) begin
         @(negedge cpu_clk); #2; i++;
      end
      if (txn_q.size() < n) begin
         fails++;
         $display("FAIL %s timeout: txns=%0d required=%0d", tag, txn_q.size(), n);
      end
   endtask

   task automatic test_reset_values(input string tag);
      tests += 11;
      if (bus.mem_ren   !== 4'h0)   begin fails++; $display("FAIL %s mem_ren=%h req 0", tag, bus.mem_ren); end
      if (bus.mem_wen   !== 4'h0)   begin fails++; $display("FAIL %s mem_wen=%h req 0", tag, bus.mem_wen); end
      if (bus.mem_raddr !== 32'h0)  begin fails++; $display("FAIL %s mem_raddr=%h req 0", tag, bus.mem_raddr); end
      if (bus.mem_waddr !== 32'h0)  begin fails++; $display("FAIL %s mem_waddr=%h req 0", tag, bus.mem_waddr); end
      if (bus.mem_wdata !== 128'h0) begin fails++; $display("FAIL %s mem_wdata=%h req 0", tag, bus.mem_wdata); end
      if (bus.ic_rvalid !== 1'b0)   begin fails++; $display("FAIL %s ic_rvalid=%b req 0", tag, bus.ic_rvalid); end
      if (bus.dc_rvalid !== 1'b0)   begin fails++; $display("FAIL %s dc_rvalid=%b req 0", tag, bus.dc_rvalid); end
      if (bus.dc_bvalid !== 1'b0)   begin fails++; $display("FAIL %s dc_bvalid=%b req 0", tag, bus.dc_bvalid); end
      if (bus.ic_rrdy   !== 1'b1)   begin fails++; $display("FAIL %s ic_rrdy=%b req 1", tag, bus.ic_rrdy); end
      if (bus.dc_rrdy   !== 1'b1)   begin fails++; $display("FAIL %s dc_rrdy=%b req 1", tag, bus.dc_rrdy); end
      if (bus.dc_wrdy   !== 1'b1)   begin fails++; $display("FAIL %s dc_wrdy=%b req 1", tag, bus.dc_wrdy); end
   endtask

   task automatic test_reset();
      #1;
      test_reset_values("reset");
      repeat (2) @(negedge cpu_clk);
      #3 cpu_rstn = 1'b1;
      repeat (2) @(negedge cpu_clk);
   endtask

   task automatic test_single_ic();
      int b, icb, dcb;
      b = txn_q.size(); icb = ic_rv_cnt; dcb = dc_rv_cnt;
      send(1'b1, 32'h0000_1230, 1'b0, 32'h0, 1'b0, 32'h0, 128'h0);
      repeat (10) @(negedge cpu_clk);
      #2;
      tests += 4;
      if (txn_q.size() !== b + 1) begin fails++; $display("FAIL single_ic count=%0d req %0d", txn_q.size() - b, 1); end
      if (txn_q[b] !== {1'b0, 32'h0000_1230}) begin fails++; $display("FAIL single_ic txn=%h req 0_00001230", txn_q[b]); end
      if (ic_rv_cnt !== icb + 1 || ic_last !== mk_data(32'h0000_1230)) begin
         fails++; $display("FAIL single_ic ic_rvalid cnt=%0d data=%h req 1 %h", ic_rv_cnt - icb, ic_last, mk_data(32'h0000_1230));
      end
      if (dc_rv_cnt !== dcb) begin fails++; $display("FAIL single_ic dc_rvalid cnt=%0d req 0", dc_rv_cnt - dcb); end
   endtask

   task automatic test_ic_dc_same_cycle();
      int b, icb, dcb;
      b = txn_q.size(); icb = ic_rv_cnt; dcb = dc_rv_cnt;
      send(1'b1, 32'h0000_0100, 1'b1, 32'h0000_0200, 1'b0, 32'h0, 128'h0);
      wait_txn(b + 2, "ic_dc");
      repeat (6) @(negedge cpu_clk);
      #2;
      tests += 5;
      if (txn_q[b] !== {1'b0, 32'h0000_0200}) begin fails++; $display("FAIL ic_dc first=%h req 0_00000200", txn_q[b]); end
      if (txn_q[b+1] !== {1'b0, 32'h0000_0100}) begin fails++; $display("FAIL ic_dc second=%h req 0_00000100", txn_q[b+1]); end
      if (txn_cyc[b+1] <= dc_rv_cyc) begin fails++; $display("FAIL ic_dc ic issue cyc=%0d not after dc resp cyc=%0d", txn_cyc[b+1], dc_rv_cyc); end
      if (ic_rv_cnt !== icb + 1 || ic_last !== mk_data(32'h0000_0100)) begin
         fails++; $display("FAIL ic_dc ic data=%h cnt=%0d req %h 1", ic_last, ic_rv_cnt - icb, mk_data(32'h0000_0100));
      end
      if (dc_rv_cnt !== dcb + 1 || dc_last !== mk_data(32'h0000_0200)) begin
         fails++; $display("FAIL ic_dc dc data=%h cnt=%0d req %h 1", dc_last, dc_rv_cnt - dcb, mk_data(32'h0000_0200));
      end
   endtask

   task automatic test_wr_before_rd();
      int b, bvb;
      b = txn_q.size(); bvb = bv_cnt;
      send(1'b0, 32'h0, 1'b1, 32'h0000_0300, 1'b1, 32'h0000_0300, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_CAFE_F00D);
      wait_txn(b + 2, "wr_rd");
      repeat (6) @(negedge cpu_clk);
      #2;
      tests += 5;
      if (txn_q[b] !== {1'b1, 32'h0000_0300}) begin fails++; $display("FAIL wr_rd first=%h req 1_00000300", txn_q[b]); end
      if (txn_q[b+1] !== {1'b0, 32'h0000_0300}) begin fails++; $display("FAIL wr_rd second=%h req 0_00000300", txn_q[b+1]); end
      if (wdata_last !== 128'hDEAD_BEEF_0123_4567_89AB_CDEF_CAFE_F00D) begin fails++; $display("FAIL wr_rd wdata=%h", wdata_last); end
      if (bv_cnt !== bvb + 1) begin fails++; $display("FAIL wr_rd bvalid cnt=%0d req 1", bv_cnt - bvb); end
      if (txn_cyc[b+1] <= bv_cyc) begin fails++; $display("FAIL wr_rd read cyc=%0d not after bvalid cyc=%0d", txn_cyc[b+1], bv_cyc); end
   endtask

   task automatic test_starvation();
      int b;
      b = txn_q.size();
      send(1'b1, 32'h0000_0400, 1'b1, 32'h0000_0500, 1'b1, 32'h0000_0600, 128'h6);
      wait_txn(b + 2, "starve");
      send(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0000_0700, 128'h7);
      wait_txn(b + 4, "starve");
      repeat (6) @(negedge cpu_clk);
      #2;
      tests += 5;
      if (txn_q[b]   !== {1'b1, 32'h0000_0600}) begin fails++; $display("FAIL starve t0=%h req 1_00000600", txn_q[b]); end
      if (txn_q[b+1] !== {1'b0, 32'h0000_0500}) begin fails++; $display("FAIL starve t1=%h req 0_00000500", txn_q[b+1]); end
      if (txn_q[b+2] !== {1'b0, 32'h0000_0400}) begin fails++; $display("FAIL starve t2=%h req 0_00000400", txn_q[b+2]); end
      if (txn_q[b+3] !== {1'b1, 32'h0000_0700}) begin fails++; $display("FAIL starve t3=%h req 1_00000700", txn_q[b+3]); end
      if (ic_last !== mk_data(32'h0000_0400)) begin fails++; $display("FAIL starve ic data=%h req %h", ic_last, mk_data(32'h0000_0400)); end
   endtask

   task automatic test_abort_inflight();
      int b, icb, rvb, i;
      b = txn_q.size(); icb = ic_rv_cnt; rvb = mem_rv_cnt;
      lat = 3;
      send(1'b1, 32'h0000_0800, 1'b0, 32'h0, 1'b0, 32'h0, 128'h0);
      wait_txn(b + 1, "abort_fl");
      @(negedge cpu_clk); bus.ic_abort = 1'b1;
      @(negedge cpu_clk); bus.ic_abort = 1'b0;
      i = 0;
      while (mem_rv_cnt == rvb && i < 20) begin
         #2; if (mem_rv_cnt == rvb) begin @(negedge cpu_clk); i++; end
      end
      tests += 4;
      if (mem_rv_cnt == rvb) begin fails++; $display("FAIL abort_fl rvalid timeout"); end
      if (bus.ic_rvalid !== 1'b0) begin fails++; $display("FAIL abort_fl ic_rvalid=%b req 0", bus.ic_rvalid); end
      if (bus.ic_rrdy !== 1'b0) begin fails++; $display("FAIL abort_fl drain ic_rrdy=%b req 0", bus.ic_rrdy); end
      @(negedge cpu_clk); #2;
      if (bus.ic_rrdy !== 1'b1 || ic_rv_cnt !== icb) begin
         fails++; $display("FAIL abort_fl after ic_rrdy=%b cnt=%0d req 1 0", bus.ic_rrdy, ic_rv_cnt - icb);
      end
      lat = 1;
   endtask

   task automatic test_abort_pending();
      int b;
      b = txn_q.size();
      @(negedge cpu_clk); bus.mem_rrdy = 1'b0;
      send(1'b1, 32'h0000_0900, 1'b0, 32'h0, 1'b0, 32'h0, 128'h0);
      bus.ic_abort = 1'b1;
      @(negedge cpu_clk); bus.ic_abort = 1'b0; bus.mem_rrdy = 1'b1;
      #2;
      tests += 3;
      if (bus.ic_rrdy !== 1'b1) begin fails++; $display("FAIL abort_pend ic_rrdy=%b req 1", bus.ic_rrdy); end
      @(negedge cpu_clk);
      bus.ic_ren = 4'hF; bus.ic_raddr = 32'h0000_0980; bus.ic_abort = 1'b1;
      @(negedge cpu_clk);
      bus.ic_ren = 4'h0; bus.ic_abort = 1'b0;
      repeat (8) @(negedge cpu_clk);
      #2;
      if (txn_q.size() !== b) begin fails++; $display("FAIL abort_pend issued=%0d req 0", txn_q.size() - b); end
      if (bus.ic_rrdy !== 1'b1) begin fails++; $display("FAIL abort_same ic_rrdy=%b req 1", bus.ic_rrdy); end
   endtask

   task automatic test_rrdy_stall();
      @(negedge cpu_clk); bus.mem_rrdy = 1'b0;
      send(1'b1, 32'h0000_0A00, 1'b0, 32'h0, 1'b0, 32'h0, 128'h0);
      for (int k = 0; k < 5; k++) begin
         @(negedge cpu_clk); #2;
         tests++;
         if (bus.mem_ren !== 4'h0) begin fails++; $display("FAIL stall cyc%0d mem_ren=%h req 0", k, bus.mem_ren); end
      end
      @(negedge cpu_clk); bus.mem_rrdy = 1'b1;
      @(negedge cpu_clk); #2;
      tests += 3;
      if (bus.mem_ren !== 4'hF || bus.mem_raddr !== 32'h0000_0A00) begin
         fails++; $display("FAIL stall issue mem_ren=%h addr=%h req F 00000a00", bus.mem_ren, bus.mem_raddr);
      end
      @(negedge cpu_clk); #2;
      if (bus.mem_ren !== 4'h0) begin fails++; $display("FAIL stall pulse mem_ren=%h req 0", bus.mem_ren); end
      repeat (6) @(negedge cpu_clk);
      if (ic_last !== mk_data(32'h0000_0A00)) begin fails++; $display("FAIL stall ic data=%h", ic_last); end
   endtask

   task automatic test_reset_mid_ic();
      int b, icb;
      b = txn_q.size(); icb = ic_rv_cnt;
      lat = 6;
      send(1'b1, 32'h0000_0B00, 1'b0, 32'h0, 1'b0, 32'h0, 128'h0);
      wait_txn(b + 1, "rst_mid");
      @(negedge cpu_clk); #2;
      tests += 3;
      if (bus.ic_rrdy !== 1'b0) begin fails++; $display("FAIL rst_mid busy ic_rrdy=%b req 0", bus.ic_rrdy); end
      cpu_rstn = 1'b0;
      #1;
      test_reset_values("rst_mid");
      @(negedge cpu_clk);
      #3 cpu_rstn = 1'b1;
      lat = 1;
      repeat (10) @(negedge cpu_clk);
      #2;
      if (ic_rv_cnt !== icb) begin fails++; $display("FAIL rst_mid ic_rvalid cnt=%0d req 0", ic_rv_cnt - icb); end
      if (bus.ic_rrdy !== 1'b1) begin fails++; $display("FAIL rst_mid after ic_rrdy=%b req 1", bus.ic_rrdy); end
   endtask

   task automatic test_spurious_idle();
      int icb, dcb, bvb;
      icb = ic_rv_cnt; dcb = dc_rv_cnt; bvb = bv_cnt;
      spur_req++;
      repeat (4) @(negedge cpu_clk);
      #2;
      tests += 2;
      if (ic_rv_cnt !== icb || dc_rv_cnt !== dcb || bv_cnt !== bvb) begin
         fails++; $display("FAIL spurious pulses ic=%0d dc=%0d bv=%0d req 0 0 0", ic_rv_cnt - icb, dc_rv_cnt - dcb, bv_cnt - bvb);
      end
      if (overlap_cnt !== 0) begin fails++; $display("FAIL overlap mem_ren&mem_wen cycles=%0d req 0", overlap_cnt); end
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

   initial begin : main
      bus.ic_ren = 4'h0; bus.ic_raddr = '0; bus.ic_abort = 1'b0;
      bus.dc_ren = 4'h0; bus.dc_raddr = '0;
      bus.dc_wen = 4'h0; bus.dc_waddr = '0; bus.dc_wdata = '0;
      bus.mem_rrdy = 1'b1; bus.mem_wrdy = 1'b1;
      test_reset();
      test_single_ic();
      test_ic_dc_same_cycle();
      test_wr_before_rd();
      test_starvation();
      test_abort_inflight();
      test_abort_pending();
      test_rrdy_stall();
      test_reset_mid_ic();
      test_spurious_idle();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
